// File: rtl/modexp_pkg.sv
// Shared types and defaults for the square-and-multiply modular exponentiation controller.
package modexp_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_EXP_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MUL  = 3'd2,
        ST_SQR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Number of set bits; used to predict multiply counts.
    function automatic int popcount(input logic [31:0] v);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            cnt += int'(v[k]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/modmul_unit.sv
// Combinational modular multiplier: y = (a*b) mod n over a full 2*WIDTH-bit product.
module modmul_unit
    import modexp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] y
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] n_wide;

    assign prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign n_wide = {{WIDTH{1'b0}}, n};

    // A zero modulus never reaches the datapath result, but keep the output defined.
    always_comb begin
        y = '0;
        if (n != '0) begin
            y = WIDTH'(prod % n_wide);
        end
    end

endmodule

// File: rtl/modexp_seq_ctrl.sv
// Sequential r = m^e mod n, right-to-left square-and-multiply on one shared multiplier.
// Define EARLY_EXIT_EN to stop once no set exponent bits remain above the current index.
module modexp_seq_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [WIDTH-1:0]     n,
    input  logic [WIDTH-1:0]     m,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     r,
    output logic                 out_err,
    output logic                 busy
);

    localparam int IDXW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(EXP_WIDTH - 1);

    state_t                 state_reg, state_next;
    logic [EXP_WIDTH-1:0]   e_reg, e_next;
    logic [WIDTH-1:0]       n_reg, n_next;
    logic [WIDTH-1:0]       base_reg, base_next;
    logic [WIDTH-1:0]       acc_reg, acc_next;
    logic [IDXW-1:0]        idx_reg, idx_next;
    logic                   err_reg, err_next;

    logic [WIDTH-1:0]       mul_a, mul_b, mul_y;
    logic [IDXW-1:0]        idx_inc;
    logic                   remain_cur, remain_inc;

    assign idx_inc = idx_reg + IDXW'(1);

`ifdef EARLY_EXIT_EN
    assign remain_cur = |((e_reg >> idx_reg) >> 1);
    assign remain_inc = |((e_reg >> idx_inc) >> 1);
`else
    assign remain_cur = (idx_reg < LAST_IDX);
    assign remain_inc = (idx_inc < LAST_IDX);
`endif

    modmul_unit #(.WIDTH(WIDTH)) u_modmul (
        .a (mul_a),
        .b (mul_b),
        .n (n_reg),
        .y (mul_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            e_reg     <= '0;
            n_reg     <= '0;
            base_reg  <= '0;
            acc_reg   <= '0;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            e_reg     <= e_next;
            n_reg     <= n_next;
            base_reg  <= base_next;
            acc_reg   <= acc_next;
            idx_reg   <= idx_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        e_next     = e_reg;
        n_next     = n_reg;
        base_next  = base_reg;
        acc_next   = acc_reg;
        idx_next   = idx_reg;
        err_next   = err_reg;
        mul_a      = base_reg;
        mul_b      = base_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    e_next     = e;
                    n_next     = n;
                    base_next  = m;
                    acc_next   = '0;
                    idx_next   = '0;
                    err_next   = 1'b0;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // base_reg still holds the raw m here; reduce it as m*1 mod n.
                mul_a = base_reg;
                mul_b = WIDTH'(1);
                if (n_reg == '0) begin
                    acc_next   = '0;
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    base_next = mul_y;
                    acc_next  = (n_reg == WIDTH'(1)) ? '0 : WIDTH'(1);
                    if (e_reg[0])
                        state_next = ST_MUL;
                    else if (remain_cur)
                        state_next = ST_SQR;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_MUL: begin
                mul_a      = acc_reg;
                mul_b      = base_reg;
                acc_next   = mul_y;
                state_next = remain_cur ? ST_SQR : ST_DONE;
            end
            ST_SQR: begin
                base_next = mul_y;
                idx_next  = idx_inc;
                if (e_reg[idx_inc])
                    state_next = ST_MUL;
                else if (remain_inc)
                    state_next = ST_SQR;
                else
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_MUL) || (state_reg == ST_SQR);
    assign r         = out_valid ? acc_reg : '0;
    assign out_err   = out_valid & err_reg;

endmodule
